// File: rtl/array_arbiter_pkg.sv
// Shared types and sizes for the round-robin array arbiter.
// Bank depth, index widths, FSM state and bank-select encodings.
package array_arbiter_pkg;

  localparam int unsigned NUM_ELEM   = 4;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned RID_W      = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Access descriptor of the winning requester (data travels separately).
  typedef struct packed {
    logic              we;
    bank_e             bank;
    logic [ADDR_W-1:0] addr;
  } acc_t;

endpackage

// File: rtl/array_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: priority starts at (last+1) and wraps.
// Purely combinational; the caller owns the last-grant register.
module rr_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [RID_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  // Scan indices above last first, then wrap to the ones at or below it.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/array_arbiter.sv
// Multi-requester access to a packed bank A and unpacked bank B with
// round-robin arbitration, registered read return and a 4-cycle clear sweep.
module array_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ-1:0]         sel,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  input  logic                       clr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic [RID_W-1:0]           rid,
  output logic                       busy,
  output logic [NUM_ELEM*DATA_W-1:0] a_q
);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [RID_W-1:0]               last_q, last_d;

  logic [NUM_ELEM-1:0][DATA_W-1:0] bank_a_q;
  logic [DATA_W-1:0]               bank_b_q [NUM_ELEM];

  logic                           rvalid_q;
  logic [DATA_W-1:0]              rdata_q;
  logic [RID_W-1:0]               rid_q;

  logic [NUM_REQ-1:0]             rr_gnt;
  logic [RID_W-1:0]               win_idx;
  acc_t                           win_acc;
  logic [DATA_W-1:0]              win_wdata;
  logic                           acc_en;
  logic                           sweep_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // Pull the winning requester's fields out of the flattened port vectors.
  always_comb begin
    win_idx   = '0;
    win_acc   = '0;
    win_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (rr_gnt[i]) begin
        win_idx       = RID_W'(i);
        win_acc.we    = we[i];
        win_acc.bank  = bank_e'(sel[i]);
        win_acc.addr  = addr[i*ADDR_W +: ADDR_W];
        win_wdata     = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= RID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // clr wins over req in IDLE; the sweep masks grants until it finishes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt      = '0;
    busy     = 1'b0;
    acc_en   = 1'b0;
    sweep_en = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            state_d = SWEEP;
            cnt_d   = '0;
          end else if (|rr_gnt) begin
            gnt    = rr_gnt;
            acc_en = 1'b1;
            last_d = win_idx;
          end
        end
        SWEEP: begin
          busy     = 1'b1;
          sweep_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_ELEM - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_a_q <= '0;
      bank_b_q <= '{default: '0};
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= acc_en && !win_acc.we;
      if (sweep_en) begin
        bank_a_q[cnt_q] <= '0;
        bank_b_q[cnt_q] <= '0;
      end
      if (acc_en && win_acc.we) begin
        if (win_acc.bank == BANK_A) begin
          bank_a_q[win_acc.addr] <= win_wdata;
        end else begin
          bank_b_q[win_acc.addr] <= win_wdata;
        end
      end
      if (acc_en && !win_acc.we) begin
        rdata_q <= (win_acc.bank == BANK_A) ? bank_a_q[win_acc.addr]
                                            : bank_b_q[win_acc.addr];
        rid_q   <= win_idx;
      end
    end
  end

  // A reset landing on the return cycle kills the pending read pulse.
  assign rvalid = rvalid_q && !rst;
  assign rdata  = rdata_q;
  assign rid    = rid_q;
  assign a_q    = bank_a_q;

endmodule

// File: doc/array_arbiter.md
ARRAY_ARBITER -- requirements
Module: array_arbiter

Interface
REQ-001 Parameter NUM_REQ, 2, number of requesters; legal range 2..4.
REQ-002 Parameter DATA_W, 16, element width in bits.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req  input  NUM_REQ  per-requester access request; the requester holds it until its gnt bit is seen.
REQ-006 Port we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-007 Port sel  input  NUM_REQ  per-requester bank select (0 = packed bank A, 1 = unpacked bank B).
REQ-008 Port addr  input  NUM_REQ*2  per-requester element index 0..3.
REQ-009 Port wdata  input  NUM_REQ*DATA_W  per-requester write data.
REQ-010 Port clr  input  1  clear-sweep request, sampled in IDLE only.
REQ-011 Port gnt  output  NUM_REQ  one-hot grant, at most one bit high per cycle.
REQ-012 Port rvalid  output  1  read data valid, one-cycle pulse.
REQ-013 Port rdata  output  DATA_W  read data.
REQ-014 Port rid  output  2  index of the requester that owns rdata.
REQ-015 Port busy  output  1  high while a clear sweep runs.
REQ-016 Port a_q  output  4*DATA_W  packed mirror of bank A, with element i at bits [i*DATA_W +: DATA_W].

Function
REQ-017 Storage SHALL be bank A, a packed 4 x DATA_W array, and bank B, an unpacked 4-entry array of DATA_W words.
REQ-018 The FSM SHALL have two states: IDLE and SWEEP.
REQ-019 In IDLE with clr=1: go to SWEEP, set cnt=0, drive gnt=0 that cycle (clr beats req).
REQ-020 In IDLE with clr=0: round-robin arbitration over req, with the highest priority at (last+1) mod NUM_REQ.
REQ-021 gnt SHALL be combinational in the request cycle; the access commits at that cycle's clock edge.
REQ-022 On a grant, last SHALL update to the granted index; with no grant, last SHALL hold.
REQ-023 Granted write: bank[sel][addr] <= wdata at the edge; no rvalid.
REQ-024 Granted read: rdata, rid and rvalid SHALL be registered, with rvalid=1 exactly one cycle after gnt for one cycle.
REQ-025 A read granted in the cycle after a write to the same element SHALL return the new data.
REQ-026 In SWEEP, each cycle SHALL write A[cnt]=0 and B[cnt]=0, then cnt++; at cnt==3 return to IDLE; the sweep lasts exactly 4 cycles.
REQ-027 In SWEEP: busy=1 and gnt=0; req and clr are ignored, and requests stay pending.
REQ-028 rdata SHALL hold its last value when rvalid=0.
REQ-029 Only one access SHALL occur per cycle, so no same-cycle bank conflict is possible.

Reset
REQ-030 When rst=1 at an edge: state=IDLE, cnt=0, last=NUM_REQ-1 (requester 0 highest priority), A and B all zero, rvalid=0, rdata=0, rid=0.
REQ-031 gnt=0 and busy=0 SHALL hold while rst=1.
REQ-032 Reset during SWEEP SHALL abort the sweep.
REQ-033 Reset in the cycle after a read grant SHALL suppress that rvalid.

Structure
REQ-034 Package array_arbiter_pkg SHALL hold: NUM_ELEM=4, the DATA_W default, the state enum {IDLE, SWEEP}, and the bank-select enum {BANK_A, BANK_B}.
REQ-035 Round-robin grant logic SHALL be the sub-module rr_arbiter, with inputs req and last and output one-hot gnt.

Verification
REQ-036 Fill and read back: requester 0 writes A[i]=i+1 and B[i]=i+2 for i=0..3, then reads all → a_q=0x0004_0003_0002_0001; B reads 2,3,4,5 with rid=0.
REQ-037 Fairness: req=2'b11 held 6 cycles after reset → gnt sequence 01,10,01,10,01,10.
REQ-038 Overwrite: write A[2]=13, then read A[2] next cycle → rdata=13, rvalid 2 cycles after the write grant.
REQ-039 Clear: after the fill, pulse clr with req=2'b01 held → busy high 4 cycles, gnt=0 during them, then gnt=01; all reads return 0.
REQ-040 Reset mid-sweep: rst at sweep cycle 2 → busy=0 next cycle, all elements 0, next grant goes to requester 0.
REQ-041 Reset after a read grant: read of B[1] granted, rst next cycle → rvalid stays 0.
